// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: idle levels of the SPI pins, shared by the slave top and its synchronizers.
//   SclkIdle - SCLK idles low (CPOL=0)
//   SselIdle - slave select idles high (deselected)
//   MosiIdle - MOSI idle level
package spi_slave_pkg;

  localparam logic SclkIdle = 1'b0;
  localparam logic SselIdle = 1'b1;
  localparam logic MosiIdle = 1'b0;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-FF synchronizer plus one history FF with edge detection.
//   clk_i  - system clock
//   rst_i  - synchronous active-high reset; all FFs load ResetVal
//   d_i    - asynchronous input
//   sync_o - synchronized level
//   rise_o - one-cycle pulse on a synchronized 0->1 transition
//   fall_o - one-cycle pulse on a synchronized 1->0 transition
module spi_sync_edge #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  // [0] first stage, [1] synchronized level, [2] previous synchronized level
  logic [2:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {3{ResetVal}};
    end else begin
      sync_q <= {sync_q[1:0], d_i};
    end
  end

  assign sync_o = sync_q[1];
  assign rise_o = ~sync_q[2] & sync_q[1];
  assign fall_o = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 slave in the system clock domain, MSB first. Each received word is
// presented on rx_data with a one-cycle rx_valid strobe and echoed back during the next word.
//   clk      - system clock, at least 8x SCLK
//   rst      - synchronous active-high reset
//   spi_SCLK - SPI clock (idle low), asynchronous
//   spi_SSEL - slave select, active low
//   spi_MOSI - master-out data
//   spi_MISO - slave-out data, 0 while deselected
//   rx_data  - last complete received word
//   rx_valid - one-cycle pulse when rx_data updates
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_SCLK,
  input  logic                  spi_SSEL,
  input  logic                  spi_MOSI,
  output logic                  spi_MISO,
  output logic [WORD_WIDTH-1:0] rx_data,
  output logic                  rx_valid
);

  localparam int unsigned CntW = $clog2(WORD_WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WORD_WIDTH - 1);

  logic sclk_posedge, sclk_negedge, sclk_sync;
  logic ssel_sync, ssel_start, ssel_rise;
  logic mosi_sync, mosi_rise, mosi_fall;
  logic ssel_active;

  // All three pins go through the same depth so MOSI lines up with the SCLK edge.
  spi_sync_edge #(.ResetVal(SclkIdle)) u_sync_sclk (
    .clk_i  (clk),
    .rst_i  (rst),
    .d_i    (spi_SCLK),
    .sync_o (sclk_sync),
    .rise_o (sclk_posedge),
    .fall_o (sclk_negedge)
  );

  spi_sync_edge #(.ResetVal(SselIdle)) u_sync_ssel (
    .clk_i  (clk),
    .rst_i  (rst),
    .d_i    (spi_SSEL),
    .sync_o (ssel_sync),
    .rise_o (ssel_rise),
    .fall_o (ssel_start)
  );

  spi_sync_edge #(.ResetVal(MosiIdle)) u_sync_mosi (
    .clk_i  (clk),
    .rst_i  (rst),
    .d_i    (spi_MOSI),
    .sync_o (mosi_sync),
    .rise_o (mosi_rise),
    .fall_o (mosi_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{sclk_sync, ssel_rise, mosi_rise, mosi_fall};

  assign ssel_active = ~ssel_sync;

  logic [WORD_WIDTH-1:0] inputReg, inputReg_d;
  logic [WORD_WIDTH-1:0] outputReg, outputReg_d;
  logic [WORD_WIDTH-1:0] tx_buf_q, tx_buf_d;
  logic [WORD_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [WORD_WIDTH-1:0] rx_word;

  assign rx_word = {inputReg[WORD_WIDTH-2:0], mosi_sync};

  always_comb begin
    inputReg_d  = inputReg;
    outputReg_d = outputReg;
    tx_buf_d    = tx_buf_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    bit_cnt_d   = bit_cnt_q;

    if (!ssel_active) begin
      // Deselect aborts any partial word; tx_buf keeps the last complete word.
      bit_cnt_d = '0;
    end else if (ssel_start) begin
      // Start of a session wins over a coincident SCLK edge.
      outputReg_d = tx_buf_q;
      bit_cnt_d   = '0;
    end else begin
      if (sclk_posedge) begin
        inputReg_d = rx_word;
        if (bit_cnt_q == CntLast) begin
          bit_cnt_d  = '0;
          rx_data_d  = rx_word;
          rx_valid_d = 1'b1;
          tx_buf_d   = rx_word;
        end else begin
          bit_cnt_d = bit_cnt_q + CntW'(1);
        end
      end
      if (sclk_negedge) begin
        // Count of 0 here means a word just completed: present the next echo word.
        if (bit_cnt_q == '0) begin
          outputReg_d = tx_buf_q;
        end else begin
          outputReg_d = {outputReg[WORD_WIDTH-2:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inputReg   <= '0;
      outputReg  <= '0;
      tx_buf_q   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      bit_cnt_q  <= '0;
    end else begin
      inputReg   <= inputReg_d;
      outputReg  <= outputReg_d;
      tx_buf_q   <= tx_buf_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  assign spi_MISO = ssel_active ? outputReg[WORD_WIDTH-1] : 1'b0;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         spi_SCLK = 1'b0;
  logic         spi_SSEL = 1'b1;
  logic         spi_MOSI = 1'b0;
  logic         spi_MISO;
  logic [W-1:0] rx_data;
  logic         rx_valid;

  spi_slave #(.WORD_WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .spi_SCLK (spi_SCLK),
    .spi_SSEL (spi_SSEL),
    .spi_MOSI (spi_MOSI),
    .spi_MISO (spi_MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  logic [W-1:0] exp_rx_q[$];
  logic [W-1:0] exp_miso_q[$];
  logic [W-1:0] tx_model = '0;  // last complete word the slave should echo

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every rx_valid pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      pulses++;
      check("rx_expected", 32'(exp_rx_q.size() != 0), 32'd1);
      if (exp_rx_q.size() != 0) check("rx_data", 32'(rx_data), 32'(exp_rx_q.pop_front()));
    end
  end

  // Mode-0 master, SCLK half-period 5 clk; samples MISO just before each rising edge.
  task automatic xfer(input logic [W-1:0] tx, input int nbits, output logic [W-1:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_MOSI = tx[W-1-i];
      repeat (5) @(negedge clk);
      rx = {rx[W-2:0], spi_MISO};
      spi_SCLK = 1'b1;
      repeat (5) @(negedge clk);
      spi_SCLK = 1'b0;
    end
  endtask

  task automatic send_word(input logic [W-1:0] w);
    logic [W-1:0] got;
    exp_miso_q.push_back(tx_model);
    exp_rx_q.push_back(w);
    tx_model = w;
    xfer(w, W, got);
    check("miso_word", 32'(got), 32'(exp_miso_q.pop_front()));
  endtask

  task automatic select();
    spi_SSEL = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic deselect();
    spi_SSEL = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    int p0;
    logic [W-1:0] got;
    logic [W-1:0] in_snap;

    // Reset state
    repeat (4) @(negedge clk);
    check("rst_rx_data", 32'(rx_data), 32'h0);
    check("rst_rx_valid", 32'(rx_valid), 32'h0);
    check("rst_miso", 32'(spi_MISO), 32'h0);
    check("rst_inputReg", 32'(dut.inputReg), 32'h0);
    check("rst_outputReg", 32'(dut.outputReg), 32'h0);
    check("rst_posedge", 32'(dut.sclk_posedge), 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // First word: echo is reset tx_buf
    select();
    p0 = pulses;
    send_word(8'hFF);
    repeat (4) @(negedge clk);
    check("pulse_ff", 32'(pulses - p0), 32'd1);
    check("rxd_ff", 32'(rx_data), 32'hFF);

    // Same session, echo of previous word
    p0 = pulses;
    send_word(8'h00);
    repeat (4) @(negedge clk);
    check("pulse_00", 32'(pulses - p0), 32'd1);
    check("rxd_00", 32'(rx_data), 32'h00);

    // Back-to-back words
    p0 = pulses;
    send_word(8'hA5);
    send_word(8'h3C);
    send_word(8'h81);
    repeat (4) @(negedge clk);
    check("pulse_b2b", 32'(pulses - p0), 32'd3);
    check("rxd_81", 32'(rx_data), 32'h81);
    deselect();

    // Partial word aborted by deselect, then a full word
    p0 = pulses;
    select();
    xfer(8'hF0, 4, got);
    deselect();
    check("pulse_partial", 32'(pulses - p0), 32'd0);
    select();
    send_word(8'h55);
    repeat (4) @(negedge clk);
    check("pulse_after_partial", 32'(pulses - p0), 32'd1);
    check("rxd_55", 32'(rx_data), 32'h55);
    deselect();

    // SCLK activity while deselected is ignored
    p0 = pulses;
    in_snap = dut.inputReg;
    for (int i = 0; i < 8; i++) begin
      spi_MOSI = ~spi_MOSI;
      repeat (5) @(negedge clk);
      spi_SCLK = 1'b1;
      repeat (5) @(negedge clk);
      check("desel_miso", 32'(spi_MISO), 32'h0);
      spi_SCLK = 1'b0;
    end
    repeat (4) @(negedge clk);
    check("desel_pulse", 32'(pulses - p0), 32'd0);
    check("desel_inputReg", 32'(dut.inputReg), 32'(in_snap));

    // Reset mid-word
    select();
    xfer(8'hC3, 3, got);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_rx_data", 32'(rx_data), 32'h0);
    check("midrst_rx_valid", 32'(rx_valid), 32'h0);
    check("midrst_miso", 32'(spi_MISO), 32'h0);
    check("midrst_inputReg", 32'(dut.inputReg), 32'h0);
    rst = 1'b0;
    tx_model = '0;
    exp_rx_q.delete();
    repeat (6) @(negedge clk);
    p0 = pulses;
    send_word(8'h96);
    repeat (4) @(negedge clk);
    check("pulse_96", 32'(pulses - p0), 32'd1);
    check("rxd_96", 32'(rx_data), 32'h96);
    deselect();
    check("queue_empty", 32'(exp_rx_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
